coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
// PURPOSE
//   Front end between the raw coin-slot sensors and the vending FSM.
//   - Synchronises and debounces two sensor lines (nickel, dime).
//   - Turns each accepted insertion into a one-cycle coin code on coin[1:0].
//   - Holds one coin while the FSM is dispensing, so no coin is lost in that cycle.
//   - Flags jams (both sensors active) and rejects (dropped or invalid insertions).
// PARAMETERS
//   DEBOUNCE_CYCLES  16  consecutive stable cycles needed to change a debounced level (>=2)
//   CNT_W            8   debounce counter width; 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//   clock       in   1  single clock, rising edge
//   reset       in   1  synchronous, active-high
//   raw_nickel  in   1  nickel sensor, asynchronous, active-high, bouncy
//   raw_dime    in   1  dime sensor, asynchronous, active-high, bouncy
//   dispensed   in   1  downstream dispense flag; high = FSM ignores coin this cycle
//   coin        out  2  registered coin code: 01 nickel, 10 dime, 00 none; 11 never driven
//   reject      out  1  registered one-cycle pulse: insertion discarded
//   jam         out  1  registered level: both debounced lines high
//   pending     out  1  registered level: hold register occupied
// BEHAVIOUR
//   Reset (sync, active-high):
//   - Clears synchronisers, counters, debounced levels, hold register and all outputs.
//   - Outputs after reset: coin=00, reject=0, jam=0, pending=0.
//   - Reset mid-operation discards any held coin. No reject is raised for it.
//   - A line held high across reset release debounces normally and yields one event.
//   Synchronise: each raw line passes through a 2-flop synchroniser (s1 -> s2).
//   Debounce, per line:
//   - If s2 == debounced level, the counter clears to 0.
//   - Otherwise the counter increments.
//   - At the edge where the count would reach DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles produces nothing.
//   Event generation:
//   - Rising edge of a debounced level (vs its 1-cycle-delayed copy) is a candidate event.
//   - Nickel rise while dime debounced low -> event 01.
//   - Dime rise while nickel debounced low -> event 10.
//   - Both rise in the same cycle -> no event; reject pulses.
//   - One rises while the other is already high -> no event; reject pulses.
//   - jam = nickel_debounced & dime_debounced.
//   - No events are generated while jam=1. Falling edges generate nothing.
//   Issue / hold, evaluated each edge:
//   - dispensed=0, hold empty, event: coin <= event.
//   - dispensed=0, hold full: coin <= held code. Any new event moves into hold (pending stays 1). Otherwise the hold empties.
//   - dispensed=1: coin <= 00. An event goes into hold if it is empty; otherwise the event is dropped and reject pulses.
//   - coin is 00 in every cycle not listed above. Each code is high for exactly 1 cycle.
//   Latency:
//   - Raw line goes steadily high before edge t0, dispensed=0, no jam.
//   - coin shows the code for the single cycle after edge t0+DEBOUNCE_CYCLES+2.
//   - Each cycle dispensed is high adds 1 cycle.
//   Width/arith: counters saturate-free by construction (clear at DEBOUNCE_CYCLES). No wrap is possible.
// TESTING (DEBOUNCE_CYCLES=4)
//   1. Clean nickel: raw_nickel 0->1 before edge 10, held 20 cycles, dispensed=0
//      -> coin=01 only in the cycle after edge 16; coin=00 elsewhere; reject=0.
//   2. Bounce: raw_dime pulses high 3 cycles, low 1, repeated 3x, then held high
//      -> exactly one coin=10, at 6 cycles after the final steady rise; no extra codes.
//   3. Dispense hold: dime event arrives while dispensed=1 for 3 cycles
//      -> pending=1 for those cycles; coin=10 in the cycle after dispensed falls; pending returns to 0.
//   4. Overflow: hold full, second nickel event while dispensed=1
//      -> reject=1 for 1 cycle; only the first held code issues later.
//   5. Jam: both raw lines rise before the same edge
//      -> reject pulse once; jam=1 while both high; coin stays 00; jam=0 after both release +6 cycles.
//   6. Reset mid-hold: pending=1, then reset asserted 1 cycle
//      -> next cycle coin=00, pending=0, jam=0, reject=0; the held coin is never issued.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the nickel/dime sensors, emits one-cycle
// coin codes, holds one coin across a dispense cycle, and flags jams and rejected insertions.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_nickel,
  input  logic       raw_dime,
  input  logic       dispensed,
  output logic [1:0] coin,
  output logic       reject,
  output logic       jam,
  output logic       pending
);

  localparam int unsigned NLINES = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  // Index 0 is the nickel line, index 1 the dime line.
  logic [NLINES-1:0] s1_q, s2_q;
  logic [NLINES-1:0] deb_q, deb_d;
  logic [NLINES-1:0] deb_prev_q;
  logic [CNT_W-1:0]  cnt_q [NLINES];
  logic [CNT_W-1:0]  cnt_d [NLINES];

  hold_state_e state_q, state_d;
  logic [1:0]  held_q, held_d;
  logic [1:0]  coin_q, coin_d;
  logic        reject_q, reject_d;
  logic        jam_q, jam_d;
  logic        pending_q, pending_d;

  logic [NLINES-1:0] rise_c;
  logic [1:0]        ev_code_c;
  logic              ev_valid_c;
  logic              conflict_c;

  // Debounce: level flips only after s2 disagrees for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    for (int i = 0; i < NLINES; i++) begin
      cnt_d[i] = cnt_q[i];
      deb_d[i] = deb_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = '0;
        deb_d[i] = ~deb_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A rise only counts as a coin when the other line is quiet; otherwise it is rejected.
  always_comb begin
    rise_c     = deb_q & ~deb_prev_q;
    ev_code_c  = {rise_c[1] & ~deb_q[0], rise_c[0] & ~deb_q[1]};
    ev_valid_c = |ev_code_c;
    conflict_c = (rise_c[0] & deb_q[1]) | (rise_c[1] & deb_q[0]);
  end

  // Issue/hold FSM: one-deep buffer that absorbs a coin arriving while dispensing.
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    coin_d    = 2'b00;
    reject_d  = conflict_c;
    jam_d     = &deb_q;
    case (state_q)
      HOLD_EMPTY: begin
        if (ev_valid_c) begin
          if (dispensed) begin
            state_d = HOLD_FULL;
            held_d  = ev_code_c;
          end else begin
            coin_d = ev_code_c;
          end
        end
      end
      HOLD_FULL: begin
        if (!dispensed) begin
          coin_d = held_q;
          if (ev_valid_c) begin
            held_d = ev_code_c;
          end else begin
            state_d = HOLD_EMPTY;
          end
        end else if (ev_valid_c) begin
          reject_d = 1'b1;
        end
      end
      default: state_d = HOLD_EMPTY;
    endcase
    pending_d = (state_d == HOLD_FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      state_q    <= HOLD_EMPTY;
      held_q     <= 2'b00;
      coin_q     <= 2'b00;
      reject_q   <= 1'b0;
      jam_q      <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      s1_q       <= {raw_dime, raw_nickel};
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      state_q    <= state_d;
      held_q     <= held_d;
      coin_q     <= coin_d;
      reject_q   <= reject_d;
      jam_q      <= jam_d;
      pending_q  <= pending_d;
    end
  end

  assign coin    = coin_q;
  assign reject  = reject_q;
  assign jam     = jam_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor (DEBOUNCE_CYCLES=4): count tables, hand-timed corner sequences,
// and a long randomized run against a history-based reference model.
module tb_coin_acceptor;

  localparam int unsigned D = 4;

  logic       clock;
  logic       reset;
  logic       raw_nickel;
  logic       raw_dime;
  logic       dispensed;
  logic [1:0] coin;
  logic       reject;
  logic       jam;
  logic       pending;

  int n_total = 0;
  int n_bad   = 0;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_nickel (raw_nickel),
    .raw_dime   (raw_dime),
    .dispensed  (dispensed),
    .coin       (coin),
    .reject     (reject),
    .jam        (jam),
    .pending    (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, then sample just after the rising edge.
  task automatic do_edge(input bit rn, input bit rd, input bit ds, input bit rs);
    @(negedge clock);
    raw_nickel = rn;
    raw_dime   = rd;
    dispensed  = ds;
    reset      = rs;
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit       m_s1 [2];
  bit       m_s2 [2];
  bit       m_deb [2];
  bit       m_debp [2];
  bit       hist_n [$];
  bit       hist_d [$];
  bit       m_full;
  bit [1:0] m_held;
  bit [1:0] e_coin;
  bit       e_rej, e_jam, e_pend;

  // True when the last D synchronised samples all disagree with the current level.
  function automatic bit settled_other(input bit q[$], input bit lvl);
    if (q.size() < D) return 1'b0;
    foreach (q[j]) if (q[j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit rn, input bit rd, input bit ds, input bit rs);
    bit [1:0] ev;
    bit       bad;
    bit       nd [2];
    if (rs) begin
      m_s1 = '{0, 0}; m_s2 = '{0, 0}; m_deb = '{0, 0}; m_debp = '{0, 0};
      hist_n.delete(); hist_d.delete();
      m_full = 0; m_held = 0;
      e_coin = 0; e_rej = 0; e_jam = 0; e_pend = 0;
      return;
    end
    ev = 0; bad = 0;
    if (m_deb[0] && !m_debp[0]) begin
      if (m_deb[1]) bad = 1; else ev = 2'b01;
    end
    if (m_deb[1] && !m_debp[1]) begin
      if (m_deb[0]) bad = 1; else ev = 2'b10;
    end
    e_coin = 0;
    e_rej  = bad;
    if (!ds) begin
      if (m_full) begin
        e_coin = m_held;
        if (ev != 0) m_held = ev; else m_full = 0;
      end else begin
        e_coin = ev;
      end
    end else if (ev != 0) begin
      if (m_full) e_rej = 1;
      else begin m_full = 1; m_held = ev; end
    end
    e_pend = m_full;
    e_jam  = m_deb[0] & m_deb[1];
    hist_n.push_back(m_s2[0]);
    hist_d.push_back(m_s2[1]);
    if (hist_n.size() > D) void'(hist_n.pop_front());
    if (hist_d.size() > D) void'(hist_d.pop_front());
    nd[0] = settled_other(hist_n, m_deb[0]) ? ~m_deb[0] : m_deb[0];
    nd[1] = settled_other(hist_d, m_deb[1]) ? ~m_deb[1] : m_deb[1];
    m_debp = m_deb;
    m_deb  = nd;
    m_s2   = m_s1;
    m_s1   = '{rn, rd};
  endtask

  // ---------------- hand-timed sequences ----------------
  // k is the index of the edge after which outputs are checked; inputs are set before edge k.
  task automatic seq_vec(input int sid, input int k,
                         output bit rn, output bit rd, output bit ds, output bit rs,
                         output bit [1:0] ec, output bit er, output bit ej, output bit ep);
    rn = 0; rd = 0; ds = 0; rs = 0; ec = 0; er = 0; ej = 0; ep = 0;
    case (sid)
      0: begin  // clean nickel
        rn = (k < 20);
        ec = (k == 6) ? 2'b01 : 2'b00;
      end
      1: begin  // bouncing dime, steady from k=12
        rd = (k < 12) ? ((k % 4) != 3) : (k < 30);
        ec = (k == 18) ? 2'b10 : 2'b00;
      end
      2: begin  // dime held over three dispense cycles
        rd = (k < 20);
        ds = (k >= 6 && k <= 8);
        ep = (k >= 6 && k <= 8);
        ec = (k == 9) ? 2'b10 : 2'b00;
      end
      3: begin  // hold full, nickel arrives while still dispensing
        rd = (k < 4);
        rn = (k >= 8 && k < 30);
        ds = (k >= 6 && k <= 14);
        ep = (k >= 6 && k <= 14);
        er = (k == 14);
        ec = (k == 15) ? 2'b10 : 2'b00;
      end
      4: begin  // jam
        rn = (k < 20);
        rd = (k < 20);
        er = (k == 6);
        ej = (k >= 6 && k <= 25);
      end
      5: begin  // reset while a coin is held
        rd = (k < 5);
        ds = (k >= 6 && k < 12);
        rs = (k == 8);
        ep = (k == 6 || k == 7);
      end
      default: ;
    endcase
  endtask

  typedef struct {
    bit rn;
    bit rd;
    int hold;
    int n_nick;
    int n_dime;
    int n_rej;
    bit jam_end;
  } row_t;

  row_t rows [7];

  initial begin
    bit rn, rd, ds, rs, er, ej, ep;
    bit [1:0] ec;
    int cn, cd, cr;
    int life_n, life_d;
    bit lvl_n, lvl_d;

    rows[0] = '{1, 0, 20, 1, 0, 0, 0};
    rows[1] = '{0, 1, 20, 0, 1, 0, 0};
    rows[2] = '{1, 1, 20, 0, 0, 1, 1};
    rows[3] = '{1, 0, 3,  0, 0, 0, 0};
    rows[4] = '{0, 1, 3,  0, 0, 0, 0};
    rows[5] = '{0, 1, 4,  0, 1, 0, 0};
    rows[6] = '{1, 0, 4,  1, 0, 0, 0};

    raw_nickel = 0; raw_dime = 0; dispensed = 0; reset = 1;
    do_edge(0, 0, 0, 1);
    do_edge(0, 0, 0, 1);
    check("reset_coin", int'(coin), 0);
    check("reset_reject", int'(reject), 0);
    check("reset_jam", int'(jam), 0);
    check("reset_pending", int'(pending), 0);

    // Table: hold levels for a while then release, counting what comes out.
    foreach (rows[r]) begin
      do_edge(0, 0, 0, 1);
      do_edge(0, 0, 0, 0);
      cn = 0; cd = 0; cr = 0;
      for (int k = 0; k < rows[r].hold + 20; k++) begin
        if (k < rows[r].hold) do_edge(rows[r].rn, rows[r].rd, 0, 0);
        else do_edge(0, 0, 0, 0);
        if (coin == 2'b01) cn++;
        if (coin == 2'b10) cd++;
        if (coin == 2'b11) check("row_coin_illegal", int'(coin), 0);
        if (reject) cr++;
        if (k == rows[r].hold - 1) check($sformatf("row%0d_jam", r), int'(jam), int'(rows[r].jam_end));
      end
      check($sformatf("row%0d_nickels", r), cn, rows[r].n_nick);
      check($sformatf("row%0d_dimes", r), cd, rows[r].n_dime);
      check($sformatf("row%0d_rejects", r), cr, rows[r].n_rej);
    end

    for (int sid = 0; sid < 6; sid++) begin
      do_edge(0, 0, 0, 1);
      do_edge(0, 0, 0, 0);
      do_edge(0, 0, 0, 0);
      for (int k = 0; k < 45; k++) begin
        seq_vec(sid, k, rn, rd, ds, rs, ec, er, ej, ep);
        do_edge(rn, rd, ds, rs);
        check($sformatf("seq%0d_k%0d_coin", sid, k), int'(coin), int'(ec));
        check($sformatf("seq%0d_k%0d_reject", sid, k), int'(reject), int'(er));
        check($sformatf("seq%0d_k%0d_jam", sid, k), int'(jam), int'(ej));
        check($sformatf("seq%0d_k%0d_pending", sid, k), int'(pending), int'(ep));
      end
    end

    // Randomized run: each raw line holds a random level for a random number of cycles.
    life_n = 0; life_d = 0; lvl_n = 0; lvl_d = 0;
    for (int c = 0; c < 4000; c++) begin
      if (life_n == 0) begin lvl_n = 1'($urandom_range(0, 1)); life_n = $urandom_range(1, 14); end
      if (life_d == 0) begin lvl_d = 1'($urandom_range(0, 1)); life_d = $urandom_range(1, 14); end
      life_n--; life_d--;
      ds = ($urandom_range(0, 3) == 0);
      rs = (c == 0) || ($urandom_range(0, 599) == 0);
      do_edge(lvl_n, lvl_d, ds, rs);
      model_edge(lvl_n, lvl_d, ds, rs);
      check("rand_coin", int'(coin), int'(e_coin));
      check("rand_reject", int'(reject), int'(e_rej));
      check("rand_jam", int'(jam), int'(e_jam));
      check("rand_pending", int'(pending), int'(e_pend));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
